fact_engine: RTL and testbench

- Parametrised iterative factorial engine: registered datapath (down-counter, product register, output buffer) driven by a control FSM.
- Successor to the fixed-width factorial control unit: generalised data and operand width, with overflow detection, an error status and a level go/done handshake.
- Sits behind a simple start/complete interface in the pipelined processor's multi-cycle functional unit.

---
 rtl/fact_pkg.sv | 32 +++
 rtl/fact_cu.sv | 52 +++++
 rtl/fact_engine.sv | 68 ++++++
 tb/tb_fact_engine.sv | 135 +++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// Shared state encoding and per-state control words for the factorial engine.
package fact_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_LOAD  = 3'b001,
    S_CHECK = 3'b010,
    S_MUL   = 3'b011,
    S_DONE  = 3'b100,
    S_ERR   = 3'b101
  } state_t;

  // cld: load counter/clear result; cen: multiply step; s1: seed product with 1;
  // ren: capture result; ben: product write; done/err: status outputs
  typedef struct packed {
    logic cld;
    logic cen;
    logic s1;
    logic ren;
    logic ben;
    logic done;
    logic err;
  } ctrl_t;

  localparam ctrl_t CW_IDLE  = 7'b000_0000;
  localparam ctrl_t CW_LOAD  = 7'b101_0100;
  localparam ctrl_t CW_CHECK = 7'b000_1000;
  localparam ctrl_t CW_MUL   = 7'b010_0100;
  localparam ctrl_t CW_DONE  = 7'b000_0010;
  localparam ctrl_t CW_ERR   = 7'b000_0001;

endpackage

// File: rtl/fact_cu.sv
// Control FSM for the factorial engine; Moore control word decoded from state.
module fact_cu
  import fact_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  go,
  input  logic  greater,
  input  logic  ovf,
  output ctrl_t ctrl
);

  state_t state, state_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = S_IDLE;
    ctrl     = CW_IDLE;
    case (state)
      S_IDLE:  state_nx = go ? S_LOAD : S_IDLE;
      S_LOAD: begin
        ctrl     = CW_LOAD;
        state_nx = S_CHECK;
      end
      // overflow of the previous multiply is resolved here, ahead of the count test
      S_CHECK: begin
        ctrl = CW_CHECK;
        if (ovf)          state_nx = S_ERR;
        else if (greater) state_nx = S_MUL;
        else              state_nx = S_DONE;
      end
      S_MUL: begin
        ctrl     = CW_MUL;
        state_nx = S_CHECK;
      end
      S_DONE: begin
        ctrl     = CW_DONE;
        state_nx = go ? S_DONE : S_IDLE;
      end
      S_ERR: begin
        ctrl     = CW_ERR;
        state_nx = go ? S_ERR : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: rtl/fact_engine.sv
// Iterative factorial engine: down-counter, product register and result buffer
// sequenced by fact_cu; multiply overflow ends the run in an error state.
module fact_engine
  import fact_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [N_W-1:0]    n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result
);

  ctrl_t                ctrl;
  logic [N_W-1:0]       cnt;
  logic [DATA_W-1:0]    prod;
  logic [2*DATA_W-1:0]  p;
  logic                 greater;
  logic                 ovf_now;
  logic                 ovf_q;

  assign greater = cnt > N_W'(1);
  assign p       = {{DATA_W{1'b0}}, prod} * {{(2*DATA_W-N_W){1'b0}}, cnt};
  assign ovf_now = |p[2*DATA_W-1:DATA_W];

  fact_cu u_cu (
    .clk     (clk),
    .rst     (rst),
    .go      (go),
    .greater (greater),
    .ovf     (ovf_q),
    .ctrl    (ctrl)
  );

  // an overflowing step leaves cnt/prod untouched; only the flag records it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      prod   <= '0;
      ovf_q  <= 1'b0;
      result <= '0;
    end else begin
      if (ctrl.cld)                 cnt <= n;
      else if (ctrl.cen && !ovf_now) cnt <= cnt - N_W'(1);

      if (ctrl.ben) begin
        if (ctrl.s1)       prod <= DATA_W'(1);
        else if (!ovf_now) prod <= p[DATA_W-1:0];
      end

      if (ctrl.cld)      ovf_q <= 1'b0;
      else if (ctrl.cen) ovf_q <= ovf_now;

      if (ctrl.cld)                            result <= '0;
      else if (ctrl.ren && !greater && !ovf_q) result <= prod;
    end
  end

  assign busy = ctrl.cld | ctrl.ren | ctrl.cen;
  assign done = ctrl.done;
  assign err  = ctrl.err;

endmodule

// File: tb/tb_fact_engine.sv
// Directed bench: a 32-bit and an 8-bit engine share clock, reset, go and n.
module tb_fact_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [3:0]  n;
  logic        busy, done, err;
  logic [31:0] result;
  logic        busy8, done8, err8;
  logic [7:0]  result8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fact_engine #(.DATA_W(32), .N_W(4)) dut (
    .clk(clk), .rst(rst), .go(go), .n(n),
    .busy(busy), .done(done), .err(err), .result(result)
  );

  fact_engine #(.DATA_W(8), .N_W(4)) dut8 (
    .clk(clk), .rst(rst), .go(go), .n(n),
    .busy(busy8), .done(done8), .err(err8), .result(result8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts a run with go=1 at a falling edge; edge 0 is the next rising edge.
  // x_edge8 < 0 skips checks on the 8-bit engine.
  task automatic run(input string tag, input logic [3:0] nv,
                     input int x_edge, input logic x_err, input logic [31:0] x_res,
                     input int x_edge8, input logic x_err8, input logic [7:0] x_res8,
                     input bit disturb);
    int e32, e8, nbusy;
    logic f_err, f_err8;
    logic [31:0] f_res;
    logic [7:0]  f_res8;
    e32 = -1; e8 = -1; nbusy = 0;
    f_err = 1'b0; f_err8 = 1'b0; f_res = '0; f_res8 = '0;
    @(negedge clk);
    n  = nv;
    go = 1'b1;
    for (int e = 0; e < 64 && (e32 < 0 || e8 < 0); e++) begin
      @(posedge clk); #1;
      if (e32 < 0) begin
        if (done || err) begin
          e32 = e; f_err = err; f_res = result;
        end else if (busy) begin
          nbusy++;
        end
      end
      if (e8 < 0 && (done8 || err8)) begin
        e8 = e; f_err8 = err8; f_res8 = result8;
      end
      if (disturb && e == 2) begin
        n  = 4'd3;
        go = 1'b0;
      end
      if (disturb && e == 3) go = 1'b1;
    end
    chk({tag, " edge"},   e32,   x_edge);
    chk({tag, " err"},    f_err, x_err);
    chk({tag, " result"}, f_res, x_res);
    chk({tag, " busy_cycles"}, nbusy, x_edge);
    if (x_edge8 >= 0) begin
      chk({tag, " edge8"},   e8,     x_edge8);
      chk({tag, " err8"},    f_err8, x_err8);
      chk({tag, " result8"}, f_res8, x_res8);
    end
    @(posedge clk); #1;
    chk({tag, " hold_done"}, done, !x_err);
    chk({tag, " hold_err"},  err,  x_err);
    go = 1'b0;
    @(posedge clk); #1;
    chk({tag, " idle_done"},   done,   1'b0);
    chk({tag, " idle_err"},    err,    1'b0);
    chk({tag, " idle_busy"},   busy,   1'b0);
    chk({tag, " idle_result"}, result, x_res);
  endtask

  initial begin
    rst = 1'b0;
    go  = 1'b0;
    n   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy",    busy,    1'b0);
    chk("rst done",    done,    1'b0);
    chk("rst err",     err,     1'b0);
    chk("rst result",  result,  32'd0);
    chk("rst result8", result8, 8'd0);
    @(negedge clk);
    rst = 1'b1;

    run("n5",  4'd5,  10, 1'b0, 32'd120,       10, 1'b0, 8'd120, 1'b0);
    run("n0",  4'd0,   2, 1'b0, 32'd1,          2, 1'b0, 8'd1,   1'b0);
    run("n1",  4'd1,   2, 1'b0, 32'd1,          2, 1'b0, 8'd1,   1'b0);
    run("n12", 4'd12, 24, 1'b0, 32'h1C8CFC00,  -1, 1'b0, 8'd0,   1'b0);
    run("n13", 4'd13, 26, 1'b1, 32'd0,         -1, 1'b0, 8'd0,   1'b0);
    run("n7",  4'd7,  14, 1'b0, 32'd5040,      -1, 1'b0, 8'd0,   1'b1);
    run("n3",  4'd3,   6, 1'b0, 32'd6,          6, 1'b0, 8'd6,   1'b0);
    run("n6",  4'd6,  12, 1'b0, 32'd720,       10, 1'b1, 8'd0,   1'b0);

    // asynchronous reset in the middle of a multiply step
    @(negedge clk);
    n  = 4'd9;
    go = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("mid busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("arst busy",   busy,   1'b0);
    chk("arst done",   done,   1'b0);
    chk("arst err",    err,    1'b0);
    chk("arst result", result, 32'd0);
    chk("arst busy8",  busy8,  1'b0);
    go = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run("n4", 4'd4, 8, 1'b0, 32'd24, 8, 1'b0, 8'd24, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
